// File: rtl/mult_sequencer.sv
// Sequencer for an 8x8 signed add-shift multiplier. The 9-bit add/sub
// datapath lives outside; this block owns A, B, M, X, the iteration counter and control.
module mult_sequencer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic [7:0] S,
  input  logic [8:0] add_sum,
  output logic [7:0] add_x,
  output logic [7:0] add_y,
  output logic       add_fn,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic       Xval,
  output logic       busy,
  output logic       done
);

  // state    | meaning
  // IDLE     | waiting for Run; ClearA_LoadB loads B and clears A/X
  // CLEAR    | clear A/X, latch multiplicand M, reset k
  // ADD      | conditional add (subtract when k=7) of M into {X,A}
  // SHIFT    | arithmetic right shift of {X,A,B}; advance k
  // DONE     | product held until Run drops; ClearA_LoadB still loads
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] m_q, m_d;
  logic       x_q, x_d;
  logic [2:0] k_q, k_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      m_q     <= 8'h00;
      x_q     <= 1'b0;
      k_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      x_q     <= x_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    x_d     = x_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (ClearA_LoadB) begin
          b_d = S;
          a_d = 8'h00;
          x_d = 1'b0;
        end else if (Run) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        a_d     = 8'h00;
        x_d     = 1'b0;
        m_d     = S;
        k_d     = 3'd0;
        state_d = ST_ADD;
      end
      ST_ADD: begin
        if (b_q[0]) begin
          a_d = add_sum[7:0];
          x_d = add_sum[8];
        end
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        a_d = {x_q, a_q[7:1]};
        b_d = {a_q[0], b_q[7:1]};
        if (k_q == 3'd7) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = ST_ADD;
        end
      end
      ST_DONE: begin
        // A load here keeps the sequencer parked in DONE so Run can stay high.
        if (ClearA_LoadB) begin
          b_d = S;
          a_d = 8'h00;
          x_d = 1'b0;
        end else if (!Run) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign add_x  = a_q;
  assign add_y  = m_q;
  // The last partial product carries negative weight in two's complement.
  assign add_fn = (state_q == ST_ADD) && (k_q == 3'd7);
  assign Aval   = a_q;
  assign Bval   = b_q;
  assign Xval   = x_q;
  assign busy   = (state_q == ST_CLEAR) || (state_q == ST_ADD) || (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: external 9-bit add/sub model, product-level
// reference model compared every cycle, plus directed literal results.
module tb_mult_sequencer;

  logic       Clk = 1'b0;
  logic       Reset, Run, ClearA_LoadB;
  logic [7:0] S;
  logic [8:0] add_sum;
  logic [7:0] add_x, add_y, Aval, Bval;
  logic       add_fn, Xval, busy, done;

  int checks = 0;
  int failures = 0;

  mult_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .S(S),
    .add_sum(add_sum), .add_x(add_x), .add_y(add_y), .add_fn(add_fn),
    .Aval(Aval), .Bval(Bval), .Xval(Xval), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  // External datapath: sign-extend both operands to 9 bits, subtract when add_fn.
  logic [8:0] ext_x, ext_y;
  assign ext_x   = {add_x[7], add_x};
  assign ext_y   = {add_y[7], add_y};
  assign add_sum = add_fn ? (ext_x - ext_y) : (ext_x + ext_y);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 busy (cyc 0 = clear, 1..16 add/shift), 2 done.
  int ph = 0;
  int cyc = 0;
  logic [7:0] ma = 8'h00, mb = 8'h00, mm = 8'h00;
  logic       mx = 1'b0;
  logic signed [31:0] prod;

  always @(posedge Clk) begin
    if (Reset) begin
      ph = 0; cyc = 0; ma = 8'h00; mb = 8'h00; mm = 8'h00; mx = 1'b0;
    end else begin
      case (ph)
        0: begin
          if (ClearA_LoadB) begin
            mb = S; ma = 8'h00; mx = 1'b0;
          end else if (Run) begin
            ph = 1; cyc = 0;
          end
        end
        1: begin
          if (cyc == 0) mm = S;
          if (cyc == 16) begin
            prod = $signed(mb) * $signed(mm);
            {mx, ma, mb} = prod[16:0];
            ph = 2;
          end else begin
            cyc++;
          end
        end
        default: begin
          if (ClearA_LoadB) begin
            mb = S; ma = 8'h00; mx = 1'b0;
          end else if (!Run) begin
            ph = 0;
          end
        end
      endcase
    end
  end

  always @(negedge Clk) begin
    chk("busy", busy, ph == 1);
    chk("done", done, ph == 2);
    chk("add_fn", add_fn, (ph == 1) && (cyc == 15));
    if (ph != 1) begin
      chk("Aval", Aval, ma);
      chk("add_x", add_x, ma);
      chk("Bval", Bval, mb);
      chk("Xval", Xval, mx);
    end
    if (!(ph == 1 && cyc == 0)) chk("add_y", add_y, mm);
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic load_b(input logic [7:0] v);
    S = v; ClearA_LoadB = 1'b1;
    step(1);
    ClearA_LoadB = 1'b0;
  endtask

  // Raises Run and waits for done; Run is left high for the caller.
  task automatic run_mult(input logic [7:0] s, input bit disturb,
                          output logic [7:0] a, output logic [7:0] b, output logic x);
    int lat = 0;
    int fn = 0;
    S = s; Run = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (add_fn) fn++;
      if (disturb && i >= 2 && i <= 16) begin
        S = 8'($urandom);
        ClearA_LoadB = 1'($urandom);
      end else begin
        ClearA_LoadB = 1'b0;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    ClearA_LoadB = 1'b0;
    chk("latency", lat, 18);
    chk("add_fn_count", fn, 1);
    a = Aval; b = Bval; x = Xval;
  endtask

  task automatic drop_run();
    Run = 1'b0;
    step(1);
  endtask

  logic [7:0] ra, rb;
  logic       rx;
  logic signed [31:0] p;

  initial begin
    Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; S = 8'h00;
    step(2);
    chk("rst_A", Aval, 8'h00);
    chk("rst_B", Bval, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    Reset = 1'b0;
    step(1);

    // 7 * -3
    load_b(8'h07);
    run_mult(8'hFD, 1'b0, ra, rb, rx);
    chk("m1_A", ra, 8'hFF); chk("m1_B", rb, 8'hEB); chk("m1_X", rx, 1'b1);
    // Run held well past done: no restart
    step(22);
    chk("hold_done", done, 1'b1);
    chk("hold_B", Bval, 8'hEB);
    drop_run();
    chk("drop_idle_done", done, 1'b0);
    chk("drop_idle_busy", busy, 1'b0);
    // B reused from the previous low byte: -21 * 3 = -63
    run_mult(8'h03, 1'b0, ra, rb, rx);
    chk("m2_A", ra, 8'hFF); chk("m2_B", rb, 8'hC1); chk("m2_X", rx, 1'b1);
    // load while in DONE keeps done high
    load_b(8'h80);
    chk("done_load_done", done, 1'b1);
    chk("done_load_B", Bval, 8'h80);
    chk("done_load_A", Aval, 8'h00);
    drop_run();

    // -128 * -128
    run_mult(8'h80, 1'b0, ra, rb, rx);
    chk("m3_A", ra, 8'h40); chk("m3_B", rb, 8'h00); chk("m3_X", rx, 1'b0);
    drop_run();

    load_b(8'hFF);
    run_mult(8'hFF, 1'b0, ra, rb, rx);
    chk("m4_A", ra, 8'h00); chk("m4_B", rb, 8'h01); chk("m4_X", rx, 1'b0);
    drop_run();
    load_b(8'h7F);
    run_mult(8'h7F, 1'b0, ra, rb, rx);
    chk("m5_A", ra, 8'h3F); chk("m5_B", rb, 8'h01); chk("m5_X", rx, 1'b0);
    drop_run();

    // 90 * -61 with S and ClearA_LoadB toggled mid-operation
    load_b(8'h5A);
    run_mult(8'hC3, 1'b1, ra, rb, rx);
    chk("m6_A", ra, 8'hEA); chk("m6_B", rb, 8'h8E); chk("m6_X", rx, 1'b1);
    drop_run();

    // reset during SHIFT with k=3 (ninth cycle after Run is sampled)
    load_b(8'h55);
    S = 8'h33; Run = 1'b1;
    step(9);
    chk("pre_rst_busy", busy, 1'b1);
    Run = 1'b0; Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_A", Aval, 8'h00);
    chk("abort_B", Bval, 8'h00);
    chk("abort_M", add_y, 8'h00);
    chk("abort_X", Xval, 1'b0);

    // reset wins over load/run; Run high at release starts a multiply
    load_b(8'h06);
    S = 8'h05; Run = 1'b1; ClearA_LoadB = 1'b1; Reset = 1'b1;
    step(2);
    chk("rst_prio_B", Bval, 8'h00);
    ClearA_LoadB = 1'b0; Reset = 1'b0;
    run_mult(8'h05, 1'b0, ra, rb, rx);
    chk("post_rst_B", rb, 8'h00);
    drop_run();

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) != 0) load_b(8'($urandom));
      p = $signed(Bval);
      S = 8'($urandom);
      p = p * $signed(S);
      run_mult(S, 1'($urandom), ra, rb, rx);
      chk("rnd_prod", {15'd0, rx, ra, rb}, {15'd0, p[16:0]});
      step($urandom_range(0, 3));
      drop_run();
      step($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
